vram_arbiter: RTL

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// VRAM s-port arbiter: one-entry CPU write buffer plus optional full-screen fill engine.
// Define VRAM_ARBITER_CLEAR_EN to build the fill engine; without it the clear ports are inert.
module vram_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_load,
    input  logic [12:0] cpu_addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        cpu_busy,
    input  logic        clear_start,
    input  logic [15:0] clear_value,
    output logic        clear_busy,
    output logic        clear_done,
    output logic        vram_load,
    output logic [12:0] vram_addr,
    output logic [15:0] vram_din,
    input  logic [15:0] vram_dout,
    input  logic        vram_busy
);

`ifdef VRAM_ARBITER_CLEAR_EN
    typedef enum logic [1:0] {IDLE, CPU_WR, CLEAR} state_t;
`else
    typedef enum logic [0:0] {IDLE, CPU_WR} state_t;
`endif

    state_t      state, state_nx;
    logic        cpu_pend;
    logic [12:0] buf_addr;
    logic [15:0] buf_data;
    logic [12:0] slot_addr, slot_addr_nx;
    logic [15:0] slot_data, slot_data_nx;
    logic        capture, accept, slot_free, cpu_cand, fill_cand;
    logic [12:0] cpu_cand_addr;
    logic [15:0] cpu_cand_data;

    // The state doubles as the occupancy tag of the registered output slot.
    assign vram_load = (state != IDLE);
    assign accept    = vram_load && !vram_busy;
    assign slot_free = !vram_load || !vram_busy;

    // A fresh capture bypasses the buffer so an idle slot issues it next cycle.
    assign capture       = cpu_load && !cpu_pend;
    assign cpu_cand      = capture || (cpu_pend && state != CPU_WR);
    assign cpu_cand_addr = capture ? cpu_addr : buf_addr;
    assign cpu_cand_data = capture ? cpu_din  : buf_data;

    assign cpu_busy  = cpu_pend;
    assign cpu_dout  = vram_dout;
    assign vram_addr = vram_load ? slot_addr : cpu_addr;
    assign vram_din  = slot_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cpu_pend <= 1'b0;
            buf_addr <= '0;
            buf_data <= '0;
        end else if (capture) begin
            cpu_pend <= 1'b1;
            buf_addr <= cpu_addr;
            buf_data <= cpu_din;
        end else if (accept && state == CPU_WR) begin
            cpu_pend <= 1'b0;
        end
    end

`ifdef VRAM_ARBITER_CLEAR_EN
    logic        fill_busy, fill_done, fill_accept, fill_last;
    logic [15:0] fill_value;
    logic [12:0] fill_cnt, fill_cnt_nx;

    // fill_cnt holds the issued address while in CLEAR, else the next address to issue.
    assign fill_accept = accept && state == CLEAR;
    assign fill_last   = fill_accept && fill_cnt == 13'h1FFF;
    assign fill_cnt_nx = fill_accept ? fill_cnt + 13'd1 : fill_cnt;
    assign fill_cand   = fill_busy && !fill_last;
    assign clear_busy  = fill_busy;
    assign clear_done  = fill_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fill_busy  <= 1'b0;
            fill_done  <= 1'b0;
            fill_value <= '0;
            fill_cnt   <= '0;
        end else begin
            fill_done <= fill_last;
            if (clear_start && !fill_busy) begin
                fill_busy  <= 1'b1;
                fill_value <= clear_value;
                fill_cnt   <= '0;
            end else begin
                fill_cnt <= fill_cnt_nx;
                if (fill_last)
                    fill_busy <= 1'b0;
            end
        end
    end
`else
    logic unused_clear;
    assign unused_clear = ^{clear_start, clear_value};
    assign fill_cand    = 1'b0;
    assign clear_busy   = 1'b0;
    assign clear_done   = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            slot_addr <= '0;
            slot_data <= '0;
        end else begin
            state     <= state_nx;
            slot_addr <= slot_addr_nx;
            slot_data <= slot_data_nx;
        end
    end

    // The slot reloads only when empty or being accepted, which keeps it stable under stall.
    always_comb begin
        state_nx     = state;
        slot_addr_nx = slot_addr;
        slot_data_nx = slot_data;
        if (slot_free) begin
            state_nx = IDLE;
            if (cpu_cand) begin
                state_nx     = CPU_WR;
                slot_addr_nx = cpu_cand_addr;
                slot_data_nx = cpu_cand_data;
            end
`ifdef VRAM_ARBITER_CLEAR_EN
            else if (fill_cand) begin
                state_nx     = CLEAR;
                slot_addr_nx = fill_cnt_nx;
                slot_data_nx = fill_value;
            end
`else
            else if (fill_cand) begin
                state_nx = IDLE;
            end
`endif
        end
    end

endmodule
